// File: rtl/nn_pkg.sv
// nn_pkg: shared state encoding, address widths and default sizes for the MLP sequencer.
package nn_pkg;
  typedef enum logic [2:0] {IDLE, L1_STREAM, L1_WAIT, SIG_WAIT, L2_STREAM, DRAIN, DONE} state_e;
  localparam int A1_W = 18;
  localparam int A2_W = 12;
  localparam int A3_W = 10;
  localparam int A6_W = 7;
  localparam int SEL_W = 7;
  localparam int N_IN_DEF = 784;
  localparam int N_HID_DEF = 32;
  localparam int N_OUT_DEF = 10;
  localparam int N_PAR_DEF = 10;
endpackage

// File: rtl/nn_addr_gen.sv
// nn_addr_gen: loop counters and running-base adders producing datapath addresses and mux select.
module nn_addr_gen
  import nn_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  parameter int N_HID = N_HID_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int N_PAR = N_PAR_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             l1_clr,
  input  logic             l1_step,
  input  logic             h_step,
  input  logic             l2_clr,
  input  logic             l2_step,
  output logic             i_last,
  output logic             h_last,
  output logic             l2_last,
  output logic [A1_W-1:0]  a1,
  output logic [A2_W-1:0]  a2,
  output logic [A3_W-1:0]  a3,
  output logic [A6_W-1:0]  a6,
  output logic [SEL_W-1:0] sel
);
  logic [A3_W-1:0] i_q, i_d;
  logic [A2_W-1:0] h_q, h_d, a2_q, a2_d;
  logic [A1_W-1:0] base1_q, base1_d;
  logic [A6_W-1:0] o_q, o_d, a6_q, a6_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic o_last;
  // a6 walks s*N_OUT+o linearly; a2 restarts at h for every new s row
  always_comb begin
    i_last = i_q == A3_W'(N_IN - 1);
    h_last = h_q == A2_W'(N_HID - 1);
    o_last = o_q == A6_W'(N_OUT - 1);
    l2_last = o_last && s_q == SEL_W'(N_PAR - 1);
    i_d = l1_clr || (l1_step && i_last) ? '0 : l1_step ? i_q + 1'b1 : i_q;
    h_d = l1_clr ? '0 : h_step ? h_q + 1'b1 : h_q;
    base1_d = l1_clr ? '0 : h_step ? base1_q + A1_W'(N_IN) : base1_q;
    o_d = l2_clr || (l2_step && o_last) ? '0 : l2_step ? o_q + 1'b1 : o_q;
    s_d = l2_clr ? '0 : l2_step && o_last ? s_q + 1'b1 : s_q;
    a2_d = l2_clr || (l2_step && o_last) ? h_q : l2_step ? a2_q + A2_W'(N_HID) : a2_q;
    a6_d = l2_clr ? '0 : l2_step ? a6_q + 1'b1 : a6_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      i_q <= '0;
      h_q <= '0;
      base1_q <= '0;
      o_q <= '0;
      s_q <= '0;
      a2_q <= '0;
      a6_q <= '0;
    end else begin
      i_q <= i_d;
      h_q <= h_d;
      base1_q <= base1_d;
      o_q <= o_d;
      s_q <= s_d;
      a2_q <= a2_d;
      a6_q <= a6_d;
    end
  end
  assign a1 = base1_q + A1_W'(i_q);
  assign a2 = a2_q;
  assign a3 = i_q;
  assign a6 = a6_q;
  assign sel = s_q;
endmodule

// File: rtl/nn_sequencer.sv
// nn_sequencer: batch FSM driving the two-layer MLP datapath; all outputs registered one cycle after the state.
module nn_sequencer
  import nn_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  parameter int N_HID = N_HID_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int N_PAR = N_PAR_DEF,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             mac1_done,
  input  logic             sig_ready,
  input  logic             mac2_done,
  output logic [A1_W-1:0]  address_1,
  output logic [A3_W-1:0]  address_3,
  output logic [A2_W-1:0]  address_2,
  output logic [A6_W-1:0]  address_6,
  output logic [SEL_W-1:0] sel,
  output logic             mac1_start,
  output logic             mac2_start,
  output logic             busy,
  output logic             done,
  output logic             error
);
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] W_MAX = WW'(TIMEOUT - 1);
  state_e state_q, state_d;
  logic [WW-1:0] wait_q;
  logic err_q, err_d, waiting, tmo;
  logic l1_clr, l1_step, h_step, l2_clr, l2_step, i_last, h_last, l2_last;
  logic [A1_W-1:0] a1, address_1_d;
  logic [A2_W-1:0] a2, address_2_d;
  logic [A3_W-1:0] a3, address_3_d;
  logic [A6_W-1:0] a6, address_6_d;
  logic [SEL_W-1:0] s, sel_d;
  logic mac1_start_d, mac2_start_d, busy_d, done_d;
  nn_addr_gen #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .N_PAR(N_PAR)) u_addr (
    .clk(clk), .reset(reset), .l1_clr(l1_clr), .l1_step(l1_step), .h_step(h_step),
    .l2_clr(l2_clr), .l2_step(l2_step), .i_last(i_last), .h_last(h_last), .l2_last(l2_last),
    .a1(a1), .a2(a2), .a3(a3), .a6(a6), .sel(s)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q <= '0;
      err_q <= 1'b0;
      address_1 <= '0;
      address_2 <= '0;
      address_3 <= '0;
      address_6 <= '0;
      sel <= '0;
      mac1_start <= 1'b0;
      mac2_start <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q <= state_d != state_q ? '0 : wait_q + 1'b1;
      err_q <= err_d;
      address_1 <= address_1_d;
      address_2 <= address_2_d;
      address_3 <= address_3_d;
      address_6 <= address_6_d;
      sel <= sel_d;
      mac1_start <= mac1_start_d;
      mac2_start <= mac2_start_d;
      busy <= busy_d;
      done <= done_d;
      error <= err_q;
    end
  end
  // wait inputs only count in their own state, so early pulses fall through
  always_comb begin
    waiting = (state_q == L1_WAIT && !mac1_done) || (state_q == SIG_WAIT && !sig_ready) ||
              (state_q == DRAIN && !mac2_done);
    tmo = waiting && wait_q == W_MAX;
    l1_clr = state_q == IDLE && go;
    l1_step = state_q == L1_STREAM;
    l2_clr = state_q == SIG_WAIT && sig_ready;
    l2_step = state_q == L2_STREAM;
    h_step = l2_step && l2_last && !h_last;
    err_d = l1_clr ? 1'b0 : tmo ? 1'b1 : err_q;
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = go ? L1_STREAM : IDLE;
      L1_STREAM: state_d = i_last ? L1_WAIT : L1_STREAM;
      L1_WAIT:   state_d = mac1_done ? SIG_WAIT : tmo ? IDLE : L1_WAIT;
      SIG_WAIT:  state_d = sig_ready ? L2_STREAM : tmo ? IDLE : SIG_WAIT;
      L2_STREAM: state_d = !l2_last ? L2_STREAM : h_last ? DRAIN : L1_STREAM;
      DRAIN:     state_d = mac2_done ? DONE : tmo ? IDLE : DRAIN;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    address_1_d = l1_step ? a1 : '0;
    address_3_d = l1_step ? a3 : '0;
    mac1_start_d = l1_step && a3 == '0;
    address_2_d = l2_step ? a2 : '0;
    address_6_d = l2_step ? a6 : '0;
    sel_d = l2_step ? s : '0;
    mac2_start_d = l2_step;
    busy_d = state_q != IDLE;
    done_d = state_q == DONE;
  end
endmodule

// File: tb/tb_nn_sequencer.sv
// tb_nn_sequencer: directed checks of the MLP sequencer with a small configuration and a scripted responder.
module tb_nn_sequencer;
  import nn_pkg::*;
  localparam int N_IN = 4;
  localparam int N_HID = 2;
  localparam int N_OUT = 3;
  localparam int N_PAR = 2;
  localparam int TIMEOUT = 16;
  logic clk = 0, reset = 1, go = 0, mac1_done = 0, sig_ready = 0, mac2_done = 0;
  logic [A1_W-1:0] address_1;
  logic [A3_W-1:0] address_3;
  logic [A2_W-1:0] address_2;
  logic [A6_W-1:0] address_6;
  logic [SEL_W-1:0] sel;
  logic mac1_start, mac2_start, busy, done, error;
  int nchk = 0, nerr = 0, n_m1 = 0, n_m2 = 0, n_done = 0, wc = 0, nt = 0;
  int t0, d1, m1b;
  bit imm = 0, resp_on = 1, m2_auto = 1;
  state_e st, st_last = IDLE;
  int a1q[$], a3q[$], a2q[$], a6q[$], selq[$];
  int exp_a2[12] = '{0, 2, 4, 0, 2, 4, 1, 3, 5, 1, 3, 5};

  always #5 clk = ~clk;

  nn_sequencer #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .N_PAR(N_PAR), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .go(go), .mac1_done(mac1_done), .sig_ready(sig_ready),
    .mac2_done(mac2_done), .address_1(address_1), .address_3(address_3), .address_2(address_2),
    .address_6(address_6), .sel(sel), .mac1_start(mac1_start), .mac2_start(mac2_start),
    .busy(busy), .done(done), .error(error)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
    nchk++;
    assert (obs === want) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // One clock: log visible outputs, then let the responder react to the new state.
  task automatic tick;
    @(posedge clk);
    #1;
    nt++;
    n_m1 += int'(mac1_start);
    n_m2 += int'(mac2_start);
    n_done += int'(done);
    if (st_last == L1_STREAM) begin
      a1q.push_back(int'(address_1));
      a3q.push_back(int'(address_3));
    end
    if (mac2_start) begin
      a2q.push_back(int'(address_2));
      a6q.push_back(int'(address_6));
      selq.push_back(int'(sel));
    end
    st = dut.state_q;
    wc = (st == st_last) ? wc + 1 : 0;
    st_last = st;
    if (imm) begin
      mac1_done = 1;
      sig_ready = 1;
      mac2_done = 1;
    end else if (resp_on) begin
      mac1_done = st == L1_WAIT && wc >= 1;
      sig_ready = st == SIG_WAIT && wc >= 1;
      if (m2_auto) mac2_done = st == DRAIN && wc >= 1;
    end
  endtask

  task automatic clear;
    n_m1 = 0;
    n_m2 = 0;
    n_done = 0;
    a1q.delete();
    a3q.delete();
    a2q.delete();
    a6q.delete();
    selq.delete();
  endtask

  task automatic pulse_go;
    go = 1;
    tick();
    go = 0;
  endtask

  task automatic run_until_done(string tag, int lim);
    int k = 0;
    while (n_done == 0 && k < lim) begin
      tick();
      k++;
    end
    chk(tag, 32'(n_done > 0), 1);
  endtask

  task automatic wait_state(string tag, state_e s, int lim);
    int k = 0;
    while (st_last != s && k < lim) begin
      tick();
      k++;
    end
    chk(tag, 32'(st_last == s), 1);
  endtask

  task automatic chk_zero(string p);
    chk({p, "_a1"}, 32'(address_1), 0);
    chk({p, "_a2"}, 32'(address_2), 0);
    chk({p, "_a3"}, 32'(address_3), 0);
    chk({p, "_a6"}, 32'(address_6), 0);
    chk({p, "_sel"}, 32'(sel), 0);
    chk({p, "_strobes"}, 32'({mac1_start, mac2_start, busy, done, error}), 0);
  endtask

  initial begin
    tick();
    tick();
    chk_zero("reset");
    reset = 0;
    tick();

    // basic batch with 2-cycle responder
    clear();
    pulse_go();
    run_until_done("basic_done_seen", 200);
    repeat (3) tick();
    chk("basic_done_cnt", 32'(n_done), 1);
    chk("basic_mac1_cnt", 32'(n_m1), 2);
    chk("basic_mac2_cnt", 32'(n_m2), 12);
    chk("basic_a1_len", 32'(a1q.size()), 8);
    chk("basic_a2_len", 32'(a2q.size()), 12);
    for (int k = 0; k < 8 && k < a1q.size(); k++) begin
      chk($sformatf("basic_a1[%0d]", k), 32'(a1q[k]), 32'(k));
      chk($sformatf("basic_a3[%0d]", k), 32'(a3q[k]), 32'(k % 4));
    end
    for (int k = 0; k < 12 && k < a2q.size(); k++) begin
      chk($sformatf("basic_a2[%0d]", k), 32'(a2q[k]), 32'(exp_a2[k]));
      chk($sformatf("basic_a6[%0d]", k), 32'(a6q[k]), 32'(k % 6));
      chk($sformatf("basic_sel[%0d]", k), 32'(selq[k]), 32'((k % 6) / 3));
    end
    chk("basic_idle", 32'({busy, error, done}), 0);

    // immediate responders: 27 rising edges from go applied to done seen
    clear();
    imm = 1;
    t0 = nt;
    pulse_go();
    run_until_done("imm_done_seen", 100);
    chk("imm_latency", 32'(nt - t0), 27);
    imm = 0;
    repeat (3) tick();

    // timeout while waiting for mac1_done
    clear();
    resp_on = 0;
    mac1_done = 0;
    sig_ready = 0;
    mac2_done = 0;
    pulse_go();
    wait_state("tmo_reach_l1wait", L1_WAIT, 50);
    repeat (16) tick();
    chk("tmo_err_before", 32'({error, busy}), 32'b01);
    tick();
    chk("tmo_err_set", 32'({error, busy}), 32'b10);
    repeat (3) tick();
    chk("tmo_err_sticky", 32'(error), 1);
    chk("tmo_no_done", 32'(n_done), 0);
    resp_on = 1;
    pulse_go();
    tick();
    chk("tmo_err_cleared", 32'({error, busy}), 32'b01);
    run_until_done("tmo_next_done", 200);

    // reset in the middle of L2_STREAM
    repeat (2) tick();
    clear();
    pulse_go();
    wait_state("rst_reach_l2", L2_STREAM, 50);
    repeat (2) tick();
    reset = 1;
    tick();
    chk_zero("midrst");
    reset = 0;
    repeat (2) tick();
    chk("midrst_no_done", 32'(n_done), 0);
    clear();
    pulse_go();
    run_until_done("midrst_restart_done", 200);
    chk("midrst_a1_len", 32'(a1q.size()), 8);
    if (a1q.size() == 8) begin
      chk("midrst_a1_first", 32'(a1q[0]), 0);
      chk("midrst_a1_h1", 32'(a1q[4]), 4);
    end

    // extra go pulse while busy is ignored
    repeat (2) tick();
    clear();
    pulse_go();
    repeat (5) tick();
    pulse_go();
    run_until_done("xgo_done_seen", 200);
    repeat (5) tick();
    chk("xgo_done_cnt", 32'(n_done), 1);
    chk("xgo_mac1_cnt", 32'(n_m1), 2);
    chk("xgo_busy", 32'(busy), 0);

    // go held high: back-to-back batches
    clear();
    d1 = -1;
    m1b = -1;
    go = 1;
    for (int k = 0; k < 200 && n_done < 2; k++) begin
      tick();
      if (done && d1 < 0) d1 = nt;
      if (mac1_start && d1 >= 0 && m1b < 0) m1b = nt;
    end
    go = 0;
    repeat (5) tick();
    chk("held_done_cnt", 32'(n_done), 2);
    chk("held_restart_gap", 32'(m1b - d1), 2);
    chk("held_mac1_cnt", 32'(n_m1), 4);
    chk("held_busy", 32'(busy), 0);

    // early mac2_done in L2_STREAM must not satisfy DRAIN
    clear();
    m2_auto = 0;
    mac2_done = 0;
    pulse_go();
    wait_state("early_reach_l2", L2_STREAM, 50);
    mac2_done = 1;
    tick();
    mac2_done = 0;
    wait_state("early_reach_drain", DRAIN, 50);
    repeat (5) tick();
    chk("early_no_done", 32'(n_done), 0);
    chk("early_busy", 32'({busy, error}), 32'b10);
    mac2_done = 1;
    run_until_done("early_done_seen", 10);
    mac2_done = 0;
    m2_auto = 1;
    chk("early_done_cnt", 32'(n_done), 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
